mux8_rr_arb: RTL and testbench
==============================

MUX8_RR_ARB -- requirements
Module: mux8_rr_arb

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive cycles one owner keeps the grant while other requests are pending (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-004 SHALL have port req, input, 8, per-requester request; bit n belongs to requester n.
REQ-005 SHALL have port din, input, 8, per-requester 1-bit data; bit n is the data of requester n.
REQ-006 SHALL have port grant, output, 8, registered one-hot (or zero) grant vector.
REQ-007 SHALL have port sel, output, 3, registered select: the binary index of the granted requester.
REQ-008 SHALL have port busy, output, 1, registered; high while any grant is active.
REQ-009 SHALL have port y, output, 1, the selected data: din[sel] when busy, 0 when not busy.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and GRANT (one owner o).
REQ-011 SHALL hold an internal round-robin pointer ptr[2:0] and a hold counter cnt[3:0].
REQ-012 In IDLE with req != 0, SHALL grant the first set req bit searching ptr, ptr+1, ... ptr+7 (mod 8), and SHALL enter GRANT with cnt=0; grant, sel and busy appear one cycle after req is sampled.
REQ-013 In IDLE with req == 0, SHALL remain in IDLE with grant=0, busy=0, and sel unchanged.
REQ-014 In GRANT, SHALL release owner o when req[o]=0, or when cnt == MAX_HOLD-1 and any req bit other than o is set.
REQ-015 In GRANT when neither release condition holds, SHALL keep the owner; cnt increments, or clears to 0 when it equals MAX_HOLD-1 (owner alone, hold renewed).
REQ-016 On release, SHALL set ptr = o+1 (mod 8) and search req from o+1 through o (owner last); if a bit is found, SHALL grant it in the next cycle with cnt=0 (back-to-back, no idle cycle); if none is found, SHALL enter IDLE.
REQ-017 When owner drop and hold limit coincide, SHALL apply the single release of REQ-016; the owner is excluded because req[o]=0.
REQ-018 SHALL keep grant at most one-hot at all times, with sel == index of the set bit whenever busy=1.
REQ-019 y SHALL be combinational from the registered sel and busy and the live din: zero added latency on data.
REQ-020 A requester whose req rises while the grant belongs to another requester SHALL NOT alter the current grant until a release condition.

Reset
REQ-021 On rst=1 at a clock edge, SHALL set state=IDLE, grant=0, sel=0, busy=0, ptr=0, cnt=0; y then reads 0.
REQ-022 Reset asserted mid-GRANT SHALL drop the grant on the same edge; the first grant after reset SHALL be searched from ptr=0.
REQ-023 While rst=1, SHALL ignore req.

Structure
REQ-024 SHALL place the constants N_REQ=8, SEL_W=3 and CNT_W=4 and the state encoding (IDLE, GRANT) in shared package mux8_arb_pkg.
REQ-025 SHALL instantiate the existing mux_8to1 as its sole sub-module for the din-to-y datapath, with select bits s2,s1,s0 = sel[2],sel[1],sel[0]; y SHALL be gated by busy.
REQ-026 SHALL keep the arbitration logic (search, pointer, counter) inside mux8_rr_arb; no further sub-modules.

Verification
REQ-027 Reset then req=8'h01 at cycle 0 -> cycle 1: grant=8'h01, sel=0, busy=1; y follows din[0].
REQ-028 After reset, req=8'hFF held with MAX_HOLD=4 -> owners 0,1,2,... each for exactly 4 cycles, back-to-back; owner 7 is followed by owner 0.
REQ-029 Owner 3 alone with req=8'h08 held for 10 cycles -> grant stays 8'h08 throughout; cnt wraps with no release.
REQ-030 Owner 5 drops req while req=8'h21 -> next cycle grant=8'h01 (search from 6 wraps to 0), ptr=6.
REQ-031 req=8'h00 after owner 2 releases -> next cycle IDLE, grant=0, busy=0, y=0 regardless of din.
REQ-032 rst pulsed for 1 cycle while owner 6 is active with req=8'hC0 -> grant=0 that cycle; next grant=8'h40 (search from ptr=0).

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// Shared constants, state encoding and the rotating priority search for the
// 8-way round-robin arbiter.
package mux8_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set bit of r scanning start, start+1, ... start+7 (mod 8).
  function automatic pick_t find_first(input logic [N_REQ-1:0] r,
                                       input logic [SEL_W-1:0] start);
    pick_t            p;
    logic [SEL_W-1:0] j;
    p = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = start + SEL_W'(i);
      if (!p.found && r[j]) begin
        p.found = 1'b1;
        p.idx   = j;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_8to1.sv
// Plain 8-to-1 single-bit multiplexer with discrete select bits.
module mux_8to1 (
  input  logic [7:0] d,
  input  logic       s2,
  input  logic       s1,
  input  logic       s0,
  output logic       y
);

  assign y = d[{s2, s1, s0}];

endmodule

// File: rtl/mux8_rr_arb.sv
// Round-robin arbiter over 8 requesters with a bounded hold time; the granted
// requester's data bit is routed combinationally to y.
module mux8_rr_arb
  import mux8_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] din,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       y
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_d;
  logic [SEL_W-1:0]   sel_d;
  logic               busy_d;
  logic [SEL_W-1:0]   start;
  pick_t              pick;
  logic               at_limit;
  logic               release_o;
  logic               mux_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant   <= '0;
      sel     <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant   <= grant_d;
      sel     <= sel_d;
      busy    <= busy_d;
    end
  end

  // One search serves both cases: from ptr when idle, from owner+1 on release
  // (the owner is naturally scanned last).
  assign start     = (state_q == IDLE) ? ptr_q : sel + 3'd1;
  assign pick      = find_first(req, start);
  assign at_limit  = (cnt_q == HOLD_LAST);
  assign release_o = !req[sel] || (at_limit && |(req & ~grant));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant;
    sel_d   = sel;
    busy_d  = busy;
    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d = GRANT;
          grant_d = N_REQ'(1) << pick.idx;
          sel_d   = pick.idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        if (release_o) begin
          ptr_d = sel + 3'd1;
          cnt_d = '0;
          if (pick.found) begin
            grant_d = N_REQ'(1) << pick.idx;
            sel_d   = pick.idx;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = at_limit ? '0 : cnt_q + 4'd1;
        end
      end
    endcase
  end

  mux_8to1 u_mux (
    .d  (din),
    .s2 (sel[2]),
    .s1 (sel[1]),
    .s0 (sel[0]),
    .y  (mux_y)
  );

  assign y = mux_y & busy;

endmodule

// File: tb/tb_mux8_rr_arb.sv
// Self-checking bench for mux8_rr_arb: vector table plus a full-request sweep.
module tb_mux8_rr_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] din;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       y;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
  } exp_t;

  localparam int NV = 26;
  vec_t tbl[NV];
  exp_t sb[$];

  mux8_rr_arb #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .din   (din),
    .grant (grant),
    .sel   (sel),
    .busy  (busy),
    .y     (y)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [7:0] q, input logic [7:0] d,
                              input logic [7:0] g, input logic [2:0] s, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.din = d; v.grant = g; v.sel = s; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [7:0] got,
                     input logic [7:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, got, exp);
    end
  endtask

  task automatic step(input int idx, input logic r, input logic [7:0] q,
                      input logic [7:0] d, input logic [7:0] g, input logic [2:0] s,
                      input logic b);
    exp_t e;
    logic ey;
    rst = r; req = q; din = d;
    e.grant = g; e.sel = s; e.busy = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e  = sb.pop_front();
    ey = e.busy ? din[e.sel] : 1'b0;
    chk("grant",  idx, grant, e.grant);
    chk("sel",    idx, {5'b0, sel}, {5'b0, e.sel});
    chk("busy",   idx, {7'b0, busy}, {7'b0, e.busy});
    chk("y",      idx, {7'b0, y}, {7'b0, ey});
    chk("onehot", idx, {7'b0, $onehot0(grant)}, 8'h01);
  endtask

  initial begin
    int unsigned o;
    logic [7:0]  d;
    rst = 1'b1; req = '0; din = '0;

    tbl[0]  = mk(1, 8'hFF, 8'h00, 8'h00, 3'd0, 0);  // req ignored in reset
    tbl[1]  = mk(0, 8'h01, 8'h01, 8'h01, 3'd0, 1);
    tbl[2]  = mk(0, 8'h01, 8'h00, 8'h01, 3'd0, 1);
    tbl[3]  = mk(0, 8'h00, 8'hFF, 8'h00, 3'd0, 0);  // idle, y gated
    tbl[4]  = mk(0, 8'h08, 8'h08, 8'h08, 3'd3, 1);
    for (int i = 5; i <= 13; i++)
      tbl[i] = mk(0, 8'h08, (i % 2) ? 8'h08 : 8'h00, 8'h08, 3'd3, 1);
    tbl[14] = mk(0, 8'h20, 8'h20, 8'h20, 3'd5, 1);
    tbl[15] = mk(0, 8'h21, 8'h01, 8'h20, 3'd5, 1);
    tbl[16] = mk(0, 8'h01, 8'h01, 8'h01, 3'd0, 1);  // search from 6 wraps to 0
    tbl[17] = mk(0, 8'h41, 8'h40, 8'h01, 3'd0, 1);
    tbl[18] = mk(0, 8'h40, 8'h40, 8'h40, 3'd6, 1);
    tbl[19] = mk(0, 8'hC0, 8'h00, 8'h40, 3'd6, 1);
    tbl[20] = mk(1, 8'hC0, 8'hFF, 8'h00, 3'd0, 0);  // reset mid-grant
    tbl[21] = mk(0, 8'hC0, 8'h40, 8'h40, 3'd6, 1);
    tbl[22] = mk(0, 8'h00, 8'hFF, 8'h00, 3'd6, 0);  // sel held in idle, ptr=7
    tbl[23] = mk(1, 8'h81, 8'hFF, 8'h00, 3'd0, 0);
    tbl[24] = mk(0, 8'h81, 8'h80, 8'h01, 3'd0, 1);  // search restarts at 0
    tbl[25] = mk(0, 8'h00, 8'h00, 8'h00, 3'd0, 0);

    for (int i = 0; i < NV; i++)
      step(i, tbl[i].rst, tbl[i].req, tbl[i].din, tbl[i].grant, tbl[i].sel, tbl[i].busy);

    // Full-request sweep: each owner holds exactly four cycles, 7 wraps to 0.
    step(100, 1'b1, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0);
    for (int k = 0; k < 36; k++) begin
      o = (k / 4) % 8;
      d = 8'($urandom);
      step(200 + k, 1'b0, 8'hFF, d, 8'(1) << o, 3'(o), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
